// File: rtl/dcl_pkg.sv
// Shared definitions for the DCL cluster-finding blocks.
//   state_t     : scanner FSM state encoding (IDLE waits for an event,
//                 EMIT streams cluster words for the latched event)
//   DEF_NSTRIP  : default hit-vector width in strips
//   DEF_NBR     : default number of neighbour strips reported below a seed
//   DEF_MAX_CL  : default maximum number of clusters emitted per event
package dcl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int DEF_NSTRIP = 128;
  localparam int DEF_NBR    = 3;
  localparam int DEF_MAX_CL = 8;

endpackage

// File: rtl/cluster_prienc.sv
// Highest-set-bit priority encoder.
//   vec   : input vector to search
//   idx   : index of the highest set bit (0 when vec is all zero)
//   found : 1 when any bit of vec is set
module cluster_prienc #(
  parameter int NSTRIP = 128,
  parameter int AW     = $clog2(NSTRIP)
) (
  input  logic [NSTRIP-1:0] vec,
  output logic [AW-1:0]     idx,
  output logic              found
);

  // Ascending scan: the last hit written is the highest index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NSTRIP; i++) begin
      if (vec[i]) begin
        idx   = AW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cluster_scanner.sv
// Cluster scanner: accepts one hit vector per event and streams one word per
// cluster, highest strip first. Each word carries the seed strip and a
// pattern of the NBR strips directly below it; those strips are consumed.
//   clk, rst     : clock, asynchronous active-high reset
//   hit_i        : event hit vector, hit_valid_i / hit_ready_o handshake
//   cl_valid_o   : cluster word valid, cl_ready_i downstream accept
//   cl_addr_o    : seed strip index
//   cl_pat_o     : {seed, strip addr-1 .. strip addr-NBR}
//   cl_last_o    : final word of the event
//   cl_empty_o   : event had no hits (single all-zero word)
//   cl_ovf_o     : event truncated at MAX_CL clusters
module cluster_scanner
  import dcl_pkg::*;
#(
  parameter int NSTRIP = DEF_NSTRIP,
  parameter int NBR    = DEF_NBR,
  parameter int MAX_CL = DEF_MAX_CL,
  parameter int AW     = $clog2(NSTRIP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTRIP-1:0] hit_i,
  input  logic              hit_valid_i,
  output logic              hit_ready_o,
  output logic              cl_valid_o,
  input  logic              cl_ready_i,
  output logic [AW-1:0]     cl_addr_o,
  output logic [NBR:0]      cl_pat_o,
  output logic              cl_last_o,
  output logic              cl_empty_o,
  output logic              cl_ovf_o
);

  localparam int CW = $clog2(MAX_CL + 1);

  state_t            state, state_d;
  logic              load;
  logic [NSTRIP-1:0] vec, src, clr, vec_nxt;
  logic [AW-1:0]     seed;
  logic              found;
  logic [NBR:0]      pat_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              remain, at_max;

  // The first word is built straight from hit_i at the accept edge so that
  // cl_valid_o follows acceptance by one cycle; afterwards the working
  // vector feeds the encoder. hit_i only reaches registers, never outputs.
  assign src = (state == IDLE) ? hit_i : vec;

  cluster_prienc #(
    .NSTRIP (NSTRIP),
    .AW     (AW)
  ) u_prienc (
    .vec   (src),
    .idx   (seed),
    .found (found)
  );

  always_comb begin
    pat_nxt      = '0;
    pat_nxt[NBR] = found;
    for (int j = 1; j <= NBR; j++) begin
      // Neighbours below strip 0 do not exist and read as zero.
      if (found && (int'(seed) >= j))
        pat_nxt[NBR-j] = src[AW'(int'(seed) - j)];
    end
    for (int k = 0; k < NSTRIP; k++)
      clr[k] = found && (k <= int'(seed)) && (k + NBR >= int'(seed));
  end

  assign vec_nxt = src & ~clr;
  assign remain  = |vec_nxt;
  assign cnt_nxt = (state == IDLE) ? CW'(1) : cnt + CW'(1);
  assign at_max  = (cnt_nxt == CW'(MAX_CL));

  assign hit_ready_o = (state == IDLE);

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (hit_valid_i) begin
          load    = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (cl_valid_o && cl_ready_i) begin
          if (cl_last_o) state_d = IDLE;
          else           load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Output word register: loads on accept or on a consumed non-last word,
  // otherwise holds, so back-pressure freezes the word in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= '0;
      cnt        <= '0;
      cl_valid_o <= 1'b0;
      cl_addr_o  <= '0;
      cl_pat_o   <= '0;
      cl_last_o  <= 1'b0;
      cl_empty_o <= 1'b0;
      cl_ovf_o   <= 1'b0;
    end else if (load) begin
      vec        <= vec_nxt;
      cnt        <= cnt_nxt;
      cl_valid_o <= 1'b1;
      cl_addr_o  <= seed;
      cl_pat_o   <= pat_nxt;
      cl_last_o  <= !remain || at_max;
      cl_empty_o <= !found;
      cl_ovf_o   <= remain && at_max;
    end else if (cl_valid_o && cl_ready_i) begin
      vec        <= '0;
      cnt        <= '0;
      cl_valid_o <= 1'b0;
      cl_addr_o  <= '0;
      cl_pat_o   <= '0;
      cl_last_o  <= 1'b0;
      cl_empty_o <= 1'b0;
      cl_ovf_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cluster_scanner.sv
// Testbench for cluster_scanner (default parameters: 128 strips, 3
// neighbours, 8 clusters per event). Table of expected cluster words plus
// hand-written back-pressure and mid-event reset sequences.
module tb_cluster_scanner;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] hit;
  logic         hit_valid;
  logic         hit_ready;
  logic         cl_valid;
  logic         cl_ready;
  logic [6:0]   cl_addr;
  logic [3:0]   cl_pat;
  logic         cl_last;
  logic         cl_empty;
  logic         cl_ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cluster_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .hit_i       (hit),
    .hit_valid_i (hit_valid),
    .hit_ready_o (hit_ready),
    .cl_valid_o  (cl_valid),
    .cl_ready_i  (cl_ready),
    .cl_addr_o   (cl_addr),
    .cl_pat_o    (cl_pat),
    .cl_last_o   (cl_last),
    .cl_empty_o  (cl_empty),
    .cl_ovf_o    (cl_ovf)
  );

  typedef struct {
    logic [127:0] hit;
    logic         start;
    logic [6:0]   addr;
    logic [3:0]   pat;
    logic         last;
    logic         empty;
    logic         ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [127:0] h, input logic s, input logic [6:0] a,
                     input logic [3:0] p, input logic l, input logic e, input logic o);
    vec_t r;
    r.hit = h; r.start = s; r.addr = a; r.pat = p;
    r.last = l; r.empty = e; r.ovf = o;
    tbl.push_back(r);
  endtask

  function automatic logic [127:0] bit_at(input int n);
    logic [127:0] one;
    one = 128'd1;
    return one << n;
  endfunction

  // {valid, addr, pat, last, empty, ovf}
  function automatic logic [14:0] word(input logic [6:0] a, input logic [3:0] p,
                                       input logic l, input logic e, input logic o);
    return {1'b1, a, p, l, e, o};
  endfunction

  function automatic logic [14:0] act_word();
    return {cl_valid, cl_addr, cl_pat, cl_last, cl_empty, cl_ovf};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [127:0] h);
    hit       = h;
    hit_valid = 1'b1;
    @(negedge clk);
    hit_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] h;

    rst       = 1'b1;
    hit       = '0;
    hit_valid = 1'b0;
    cl_ready  = 1'b0;

    // ---- reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", {hit_ready, act_word()}, {1'b1, 15'd0});
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst", {hit_ready, act_word()}, {1'b1, 15'd0});

    // ---- table of events and their expected words
    h = bit_at(127) | bit_at(126) | bit_at(5);
    add(h, 1, 7'd127, 4'b1100, 0, 0, 0);
    add(h, 0, 7'd5,   4'b1000, 1, 0, 0);
    add(bit_at(0), 1, 7'd0, 4'b1000, 1, 0, 0);
    add('0, 1, 7'd0, 4'b0000, 1, 1, 0);
    add(bit_at(10) | bit_at(8) | bit_at(7), 1, 7'd10, 4'b1011, 1, 0, 0);
    add(bit_at(2) | bit_at(1), 1, 7'd2, 4'b1100, 1, 0, 0);
    h = '0;
    for (int k = 0; k < 12; k++) h |= bit_at(10 * k);
    for (int j = 0; j < 8; j++)
      add(h, (j == 0), 7'(110 - 10 * j), 4'b1000, (j == 7), 0, (j == 7));
    h = bit_at(50) | bit_at(46);
    add(h, 1, 7'd50, 4'b1000, 0, 0, 0);
    add(h, 0, 7'd46, 4'b1000, 1, 0, 0);

    cl_ready = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].start) send(tbl[i].hit);
      chk($sformatf("tbl_word%0d", i), act_word(),
          word(tbl[i].addr, tbl[i].pat, tbl[i].last, tbl[i].empty, tbl[i].ovf));
      @(negedge clk);
      if (tbl[i].last)
        chk($sformatf("tbl_idle%0d", i), {cl_valid, hit_ready}, 2'b01);
    end

    // ---- back-pressure for 5 cycles; hit_valid held high during EMIT
    send(bit_at(100) | bit_at(60) | bit_at(20));
    chk("bp_w1", act_word(), word(7'd100, 4'b1000, 0, 0, 0));
    @(negedge clk);
    cl_ready  = 1'b0;
    hit       = '1;
    hit_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold%0d", c), act_word(), word(7'd60, 4'b1000, 0, 0, 0));
      @(negedge clk);
    end
    cl_ready = 1'b1;
    chk("bp_w2", act_word(), word(7'd60, 4'b1000, 0, 0, 0));
    @(negedge clk);
    chk("bp_w3", act_word(), word(7'd20, 4'b1000, 1, 0, 0));
    @(negedge clk);
    // hit_valid was high when the last word was taken: must not be accepted
    chk("bp_no_accept", {cl_valid, hit_ready}, 2'b01);
    hit_valid = 1'b0;
    hit       = '0;
    @(negedge clk);

    // ---- reset pulse during the second word
    send(bit_at(90) | bit_at(80));
    chk("rs_w1", act_word(), word(7'd90, 4'b1000, 0, 0, 0));
    @(negedge clk);
    chk("rs_w2", act_word(), word(7'd80, 4'b1000, 1, 0, 0));
    rst = 1'b1;
    #1;
    chk("rs_async", {hit_ready, act_word()}, {1'b1, 15'd0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rs_after", {hit_ready, act_word()}, {1'b1, 15'd0});
    send(bit_at(3));
    chk("rs_new", act_word(), word(7'd3, 4'b1000, 1, 0, 0));
    @(negedge clk);
    chk("rs_idle", {cl_valid, hit_ready}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cluster_scanner.md
CLUSTER_SCANNER -- requirements
Module: cluster_scanner

Interface
REQ-001 SHALL have parameter NSTRIP, default 128: hit-vector width in strips.
REQ-002 SHALL have parameter NBR, default 3: neighbour strips reported below each seed.
REQ-003 SHALL have parameter MAX_CL, default 8: maximum clusters emitted per event.
REQ-004 SHALL have derived parameter AW = clog2(NSTRIP): address width.
REQ-005 SHALL have port clk  in  1: single clock; all logic rising-edge.
REQ-006 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-007 SHALL have port hit_i  in  NSTRIP: event hit vector.
REQ-008 SHALL have port hit_valid_i  in  1: hit_i valid.
REQ-009 SHALL have port hit_ready_o  out  1: scanner accepts a new event.
REQ-010 SHALL have port cl_valid_o  out  1: cluster word valid.
REQ-011 SHALL have port cl_ready_i  in  1: downstream accepts the cluster word.
REQ-012 SHALL have port cl_addr_o  out  AW: seed strip index.
REQ-013 SHALL have port cl_pat_o  out  NBR+1: MSB = seed (always 1 for a real cluster); lower bits = strips addr-1 .. addr-NBR.
REQ-014 SHALL have port cl_last_o  out  1: final word of the event.
REQ-015 SHALL have port cl_empty_o  out  1: event contained no hits.
REQ-016 SHALL have port cl_ovf_o  out  1: event truncated at MAX_CL.

Function
REQ-017 SHALL use FSM states IDLE and EMIT; hit_ready_o = 1 only in IDLE.
REQ-018 SHALL latch hit_i into the working vector on hit_valid_i & hit_ready_o and go to EMIT; cl_valid_o SHALL rise exactly one cycle after accept.
REQ-019 SHALL select the seed as the highest-index set bit of the working vector.
REQ-020 SHALL form cl_pat_o as {1, vec[seed-1], ..., vec[seed-NBR]}, with positions below index 0 zero-filled (seed=0, NBR=3 -> 4'b1000).
REQ-021 SHALL, when loading a word, clear strips seed .. max(seed-NBR,0) from the working vector and increment the cluster count.
REQ-022 SHALL hold all cl_* outputs stable while cl_valid_o=1 and cl_ready_i=0.
REQ-023 SHALL, on cl_valid_o & cl_ready_i with cl_last_o=0, register the next word in the same edge, giving back-to-back words with no bubble.
REQ-024 SHALL assert cl_last_o when the working vector is empty after clearing, or when the count reaches MAX_CL.
REQ-025 SHALL assert cl_ovf_o, together with cl_last_o, only when the count reaches MAX_CL and set bits remain.
REQ-026 SHALL, for an all-zero event, emit one word: cl_empty_o=1, cl_last_o=1, cl_addr_o=0, cl_pat_o=0.
REQ-027 SHALL return to IDLE on acceptance of the last word; a new event SHALL NOT be accepted in that same cycle.
REQ-028 SHALL ignore hit_valid_i outside IDLE; hit_i changes during EMIT have no effect.

Reset
REQ-029 SHALL, on rst high, asynchronously force IDLE, working vector 0, count 0, and all cl_* outputs 0; hit_ready_o = 1 after reset.
REQ-030 SHALL discard any in-progress event when rst is asserted mid-event, with no word emitted after release.

Structure
REQ-031 SHALL take the FSM state encodings and the default NSTRIP, NBR and MAX_CL values from the shared DCL package dcl_pkg.
REQ-032 SHALL instantiate one sub-module, cluster_prienc: a parametrised NSTRIP-wide highest-set-bit encoder with a found flag.
REQ-033 SHALL be 120-400 lines of RTL with no combinational path from hit_i to any output.

Verification
REQ-034 SHALL cover: hit_i bits 127,126,5 set, ready=1 -> words (127,1100,last0), (5,1000,last1).
REQ-035 SHALL cover: hit_i = 1 << 0 -> one word: addr 0, pat 1000, last 1.
REQ-036 SHALL cover: hit_i = 0 -> one word: empty=1, last=1, addr 0, pat 0.
REQ-037 SHALL cover: 12 isolated hits, MAX_CL=8 -> 8 words; the 8th has last=1, ovf=1.
REQ-038 SHALL cover: ready low for 5 cycles mid-event -> outputs frozen, no words lost or duplicated.
REQ-039 SHALL cover: rst pulse during the second word -> cl_valid_o=0 immediately; hit_ready_o=1 after release.
